// File: rtl/mod_collector_pkg.sv
// mod_collector_pkg: shared types and helpers for the round-robin collector.
//   COL_PORT_COUNT / COL_IN_WIDTH : build configuration that sizes collector_beat_t;
//                                   the mod_collector parameters default to these values
//   collector_beat_t              : one FIFO entry {port_id, flag, data, parity}
//   rr_pick()                     : round-robin find-first, returns {found, index}
package mod_collector_pkg;

  localparam int COL_PORT_COUNT = 6;
  localparam int COL_IN_WIDTH   = 4;
  localparam int COL_ID_W       = $clog2(COL_PORT_COUNT);

  typedef struct packed {
    logic [COL_ID_W-1:0]     port_id;
    logic                    flag;
    logic [COL_IN_WIDTH-1:0] data;
    logic                    parity;
  } collector_beat_t;

  localparam int COL_BEAT_W = $bits(collector_beat_t);

  // First set bit of vld searching upward from ptr, wrapping modulo the port
  // count. MSB of the result is the found flag.
  function automatic logic [COL_ID_W:0] rr_pick(input logic [COL_PORT_COUNT-1:0] vld,
                                                input logic [COL_ID_W-1:0]       ptr);
    logic                found;
    logic [COL_ID_W-1:0] idx;
    int                  p;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < COL_PORT_COUNT; i++) begin
      p = (int'(ptr) + i) % COL_PORT_COUNT;
      if (!found && vld[p]) begin
        found = 1'b1;
        idx   = COL_ID_W'(p);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mod_collector_fifo.sv
// mod_collector_fifo: first-word fall-through FIFO of collector_beat_t.
//   clk, rst      : clock, async active-low reset (pointers and head register)
//   push/push_beat: write request and entry (ignored when full)
//   pop           : consume head (ignored when empty)
//   head          : registered head entry, reads 0 out of reset
//   full/empty    : status
//   count         : occupancy, 0..DEPTH
module mod_collector_fifo
  import mod_collector_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  collector_beat_t push_beat,
  input  logic            pop,
  output collector_beat_t head,
  output logic            full,
  output logic            empty,
  output logic [PW-1:0]   count
);

  collector_beat_t mem_q [DEPTH];
  collector_beat_t head_q, head_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic            do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (identical).
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;
  assign head  = head_q;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    head_d  = head_q;
    // The head register mirrors the entry at the (next) read pointer. When
    // that slot is the one being written this cycle, forward the push data.
    if (do_pop) begin
      if (rd_d == wr_q) begin
        if (do_push) head_d = push_beat;
      end else begin
        head_d = mem_q[rd_d[AW-1:0]];
      end
    end else if (empty && do_push) begin
      head_d = push_beat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_beat;
  end

endmodule

// File: rtl/mod_collector.sv
// mod_collector: round-robin merge of PORT_COUNT valid/ready streams into one
// FWFT output stream tagged with source port id and even parity.
//   clk, rst                   : clock, async active-low reset
//   in_valid/in_ready          : per-port handshake (in_ready is one-hot grant or zero)
//   in0, in_data               : per-port flag bit and data (port i at [i*IN_WIDTH +: IN_WIDTH])
//   out_valid/out_ready        : output handshake
//   out_port_id/out0/out_data/out_parity : head beat fields
//   fifo_count                 : output FIFO occupancy
//   cnt_sel/cnt_val            : saturating per-port beat counter readback
module mod_collector
  import mod_collector_pkg::*;
#(
  parameter  int PORT_COUNT = COL_PORT_COUNT,
  parameter  int IN_WIDTH   = COL_IN_WIDTH,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int ID_W       = $clog2(PORT_COUNT),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_COUNT-1:0]          in_valid,
  output logic [PORT_COUNT-1:0]          in_ready,
  input  logic [PORT_COUNT-1:0]          in0,
  input  logic [PORT_COUNT*IN_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_port_id,
  output logic                           out0,
  output logic [IN_WIDTH-1:0]            out_data,
  output logic                           out_parity,
  output logic [CW-1:0]                  fifo_count,
  input  logic [ID_W-1:0]                cnt_sel,
  output logic [CNT_WIDTH-1:0]           cnt_val
);

  logic [ID_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [PORT_COUNT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ID_W:0]                        pick;
  logic                                 grant;
  logic [ID_W-1:0]                      gnt_id;
  logic [IN_WIDTH-1:0]                  gnt_data;
  logic                                 fifo_full, fifo_empty, pop;
  collector_beat_t                      push_beat, head_beat;

  always_comb begin
    pick     = rr_pick(in_valid, rr_ptr_q);
    gnt_id   = pick[ID_W-1:0];
    // Full blocks the grant even when a pop happens this cycle, so in_ready
    // never depends on out_ready. Gating with rst keeps in_ready low in reset.
    grant    = rst && pick[ID_W] && !fifo_full;
    gnt_data = in_data[int'(gnt_id)*IN_WIDTH +: IN_WIDTH];
    push_beat.port_id = gnt_id;
    push_beat.flag    = in0[gnt_id];
    push_beat.data    = gnt_data;
    push_beat.parity  = in0[gnt_id] ^ (^gnt_data);

    in_ready = '0;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (grant) begin
      in_ready[gnt_id] = 1'b1;
      rr_ptr_d = (gnt_id == ID_W'(PORT_COUNT - 1)) ? '0 : gnt_id + 1'b1;
      if (cnt_q[gnt_id] != '1) cnt_d[gnt_id] = cnt_q[gnt_id] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop = !fifo_empty && out_ready;

  mod_collector_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head_beat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign out_port_id = head_beat.port_id;
  assign out0        = head_beat.flag;
  assign out_data    = head_beat.data;
  assign out_parity  = head_beat.parity;

  // Out-of-range selects fall through to 0.
  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (cnt_sel == ID_W'(i)) cnt_val = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_mod_collector.sv
module tb_mod_collector;

  logic        clk, rst;
  logic [5:0]  in_valid, in_ready, in0;
  logic [23:0] in_data;
  logic        out_valid, out_ready, out0, out_parity;
  logic [2:0]  out_port_id, fifo_count, cnt_sel;
  logic [3:0]  out_data;
  logic [7:0]  cnt_val;

  int checks = 0;
  int errors = 0;

  mod_collector #(.PORT_COUNT(6), .IN_WIDTH(4), .FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in0(in0), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_port_id(out_port_id),
    .out0(out0), .out_data(out_data), .out_parity(out_parity),
    .fifo_count(fifo_count), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    in_valid  = '0;
    out_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = '1; in0 = '0; in_data = '0; out_ready = 1'b1; cnt_sel = '0;
    #3;
    checks++; if (in_ready !== 6'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 000000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    checks++; if (out_data !== 4'h0 || out_port_id !== 3'd0) begin errors++; $display("FAIL reset_head got id %0d data %h exp 0 0", out_port_id, out_data); end
    in_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 6'b0) begin
      errors++; $display("FAIL post_reset_idle got v %b cnt %0d rdy %b exp 0 0 0", out_valid, fifo_count, in_ready); end
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s); #1;
      checks++; if (cnt_val !== 8'd0) begin errors++; $display("FAIL reset_cnt sel %0d got %0d exp 0", s, cnt_val); end
    end
  endtask

  task automatic test_two_ports;
    apply_reset();
    out_ready = 1'b1;
    in_data = '0; in_data[4 +: 4] = 4'h3; in_data[16 +: 4] = 4'h7;
    in0 = 6'b000010; in_valid = 6'b010010;
    #1;
    checks++; if (in_ready !== 6'b000010) begin errors++; $display("FAIL two_rdy1 got %b exp 000010", in_ready); end
    tick();
    in_valid = 6'b010000; #1;
    checks++; if (out_valid !== 1'b1 || out_port_id !== 3'd1 || out_data !== 4'h3 || out0 !== 1'b1 || out_parity !== 1'b1) begin
      errors++; $display("FAIL two_beat1 got v %b id %0d d %h f %b p %b exp 1 1 3 1 1", out_valid, out_port_id, out_data, out0, out_parity); end
    checks++; if (in_ready !== 6'b010000) begin errors++; $display("FAIL two_rdy2 got %b exp 010000", in_ready); end
    tick();
    in_valid = '0; #1;
    checks++; if (out_valid !== 1'b1 || out_port_id !== 3'd4 || out_data !== 4'h7 || out0 !== 1'b0 || out_parity !== 1'b1) begin
      errors++; $display("FAIL two_beat2 got v %b id %0d d %h f %b p %b exp 1 4 7 0 1", out_valid, out_port_id, out_data, out0, out_parity); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL two_count got %0d exp 1", fifo_count); end
    tick();
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL two_drain got v %b cnt %0d exp 0 0", out_valid, fifo_count); end
    cnt_sel = 3'd1; #1;
    checks++; if (cnt_val !== 8'd1) begin errors++; $display("FAIL two_cnt1 got %0d exp 1", cnt_val); end
    cnt_sel = 3'd4; #1;
    checks++; if (cnt_val !== 8'd1) begin errors++; $display("FAIL two_cnt4 got %0d exp 1", cnt_val); end
    cnt_sel = 3'd0; #1;
    checks++; if (cnt_val !== 8'd0) begin errors++; $display("FAIL two_cnt0 got %0d exp 0", cnt_val); end
  endtask

  task automatic test_round_robin;
    int exp;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) in_data[i*4 +: 4] = 4'(i + 8);
    in0 = 6'b101010; in_valid = '1;
    #1;
    for (int k = 0; k < 12; k++) begin
      exp = k % 6;
      checks++; if (in_ready !== 6'(1 << exp)) begin errors++; $display("FAIL rr_rdy k %0d got %b exp port %0d", k, in_ready, exp); end
      tick();
      checks++; if (out_port_id !== 3'(exp) || out_data !== 4'(exp + 8)) begin
        errors++; $display("FAIL rr_beat k %0d got id %0d d %h exp %0d %h", k, out_port_id, out_data, exp, 4'(exp + 8)); end
    end
    in_valid = '0;
    tick();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rr_drain got %0d exp 0", fifo_count); end
    for (int p = 0; p < 6; p++) begin
      cnt_sel = 3'(p); #1;
      checks++; if (cnt_val !== 8'd2) begin errors++; $display("FAIL rr_cnt port %0d got %0d exp 2", p, cnt_val); end
    end
  endtask

  task automatic test_backpressure;
    apply_reset();
    in_data = '0; in_data[8 +: 4] = 4'h5; in0 = '0; in_valid = 6'b000100; cnt_sel = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (fifo_count !== 3'(k)) begin errors++; $display("FAIL bp_fill k %0d got %0d exp %0d", k, fifo_count, k); end
    end
    tick();
    checks++; if (fifo_count !== 3'd4 || in_ready !== 6'b0 || out_valid !== 1'b1 || out_port_id !== 3'd2) begin
      errors++; $display("FAIL bp_full got cnt %0d rdy %b v %b id %0d exp 4 000000 1 2", fifo_count, in_ready, out_valid, out_port_id); end
    checks++; if (cnt_val !== 8'd4) begin errors++; $display("FAIL bp_cnt_full got %0d exp 4", cnt_val); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 6'b0) begin errors++; $display("FAIL bp_rdy_while_full got %b exp 000000", in_ready); end
    tick();
    checks++; if (fifo_count !== 3'd3 || cnt_val !== 8'd4 || in_ready !== 6'b000100) begin
      errors++; $display("FAIL bp_bubble got cnt %0d bc %0d rdy %b exp 3 4 000100", fifo_count, cnt_val, in_ready); end
    tick();
    checks++; if (fifo_count !== 3'd3 || cnt_val !== 8'd5) begin
      errors++; $display("FAIL bp_resume got cnt %0d bc %0d exp 3 5", fifo_count, cnt_val); end
    in_valid = '0;
    tick(); tick(); tick();
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got cnt %0d v %b exp 0 0", fifo_count, out_valid); end
  endtask

  task automatic test_saturation;
    apply_reset();
    out_ready = 1'b1; in_valid = 6'b000001; cnt_sel = 3'd0;
    repeat (254) tick();
    checks++; if (cnt_val !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", cnt_val); end
    repeat (46) tick();
    checks++; if (cnt_val !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", cnt_val); end
    in_valid = '0;
    tick();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL sat_drain got %0d exp 0", fifo_count); end
    cnt_sel = 3'd7; #1;
    checks++; if (cnt_val !== 8'd0) begin errors++; $display("FAIL sat_sel7 got %0d exp 0", cnt_val); end
    cnt_sel = 3'd6; #1;
    checks++; if (cnt_val !== 8'd0) begin errors++; $display("FAIL sat_sel6 got %0d exp 0", cnt_val); end
    cnt_sel = 3'd0; #1;
    checks++; if (cnt_val !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", cnt_val); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    in_data = '0; in_data[12 +: 4] = 4'h9; in0 = '0; in_valid = 6'b001000; cnt_sel = 3'd3;
    repeat (3) tick();
    in_valid = '0; #1;
    checks++; if (fifo_count !== 3'd3 || cnt_val !== 8'd3) begin errors++; $display("FAIL ar_pre got cnt %0d bc %0d exp 3 3", fifo_count, cnt_val); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || cnt_val !== 8'd0 || out_port_id !== 3'd0) begin
      errors++; $display("FAIL ar_async got v %b cnt %0d bc %0d id %0d exp 0 0 0 0", out_valid, fifo_count, cnt_val, out_port_id); end
    in_valid = '1; #1;
    checks++; if (in_ready !== 6'b0) begin errors++; $display("FAIL ar_rdy_in_reset got %b exp 000000", in_ready); end
    tick();
    rst = 1'b1; #1;
    checks++; if (in_ready !== 6'b000001) begin errors++; $display("FAIL ar_first_grant got %b exp 000001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_port_id !== 3'd0) begin errors++; $display("FAIL ar_first_beat got v %b id %0d exp 1 0", out_valid, out_port_id); end
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_two_ports();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
